pc_int_ctrl: RTL
================

Name: pc_int_ctrl

Overview:
- Next-generation program counter with a parametrised interrupt controller, driving instruction fetch address for the CPU.
- Generalises the fixed four-internal plus four-external interrupt scheme to N_INT prioritised, maskable, edge-triggered channels.
- Each channel has its own vector and reported ID.
- Advances once per rising edge of the CPU write-back strobe: handles jumps (absolute or relative), interrupt entry and return-from-interrupt.

Parameters:
- PC_W, 27: PC and jump address width.
- N_INT, 8: number of interrupt channels; index 0 is highest priority.
- RESET_PC, 0: PC value after reset.
- ROM_BASE, 27'h4000000: interrupts are accepted only while pc_out < ROM_BASE.
- VEC_BASE, 1: vector address of channel k is VEC_BASE + k.
- NEST_DEPTH, 4: return-stack depth (used only with the optional feature).

Ports:
- clk  in  1  CPU clock; all state updates on negedge clk.
- reset  in  1  asynchronous, active-low reset.
- write_back  in  1  CPU write-back strobe; its rising edge is a step event.
- jump  in  1  current instruction jumps.
- offset  in  1  jump is PC-relative.
- jump_addr  in  PC_W  jump target or offset.
- reti  in  1  return from interrupt.
- int_req  in  N_INT  interrupt request lines.
- int_mask  in  N_INT  1 = channel masked.
- pc_out  out  PC_W  current PC.
- int_id  out  clog2(N_INT)  ID of the most recently accepted interrupt.
- int_active  out  1  interrupt handler in progress.
- int_pending  out  N_INT  latched pending flags.

Behaviour:
- Reset (reset low, asynchronous):
  - pc_out = RESET_PC; int_id = 0; int_active = 0; int_pending = 0.
  - Backup PC = 0; write_back and int_req previous-value registers = 0.
- Step event: write_back high and write_back_prev low at a negedge. write_back held high produces exactly one step.
- Edge detection and pending flags, every negedge:
  - int_pending[i] is set when int_req[i] is high and its previous sample was low.
  - Masked channels still latch pending; the mask only gates acceptance.
  - A flag clears when its interrupt is accepted. A new edge arriving in the same cycle as acceptance wins: the flag stays set.
- next_pc:
  - jump with offset: pc_out + jump_addr.
  - jump without offset: jump_addr.
  - otherwise: pc_out + 1.
  - All arithmetic is modulo 2^PC_W; overflow wraps silently.
- On a step, priority is reti > interrupt entry > normal advance.
  - reti: pc_out = backup PC; int_active = 0. reti with int_active = 0 still loads the backup (RESET value 0); this is a software error.
  - Interrupt entry condition: int_active = 0, and (int_pending & ~int_mask) is nonzero, and pc_out < ROM_BASE.
  - On entry, select k = lowest set index. Then backup PC = next_pc; pc_out = VEC_BASE + k; int_id = k; int_active = 1; clear int_pending[k].
  - Otherwise: pc_out = next_pc.
- No steps occur outside write_back edges. Pending flags keep accumulating between steps.
- Latency: pc_out updates at the same negedge the step is detected.
- Reset asserted mid-handler discards the backup PC and all pending flags.

Optional Feature:
- Macro: PC_INT_NESTED_EN.
- Defined:
  - The backup register becomes a NEST_DEPTH-entry stack of {next_pc, previous int_id}.
  - Entry while int_active = 1 is allowed only if k < current int_id and the stack is not full. Entry pushes to the stack.
  - reti pops: restores pc_out and int_id. int_active clears when the stack becomes empty.
  - reti on an empty stack loads pc_out = 0.
- Undefined: single backup register; no nesting; int_active blocks all entry.

Decomposition:
- Package pc_int_pkg:
  - PC_W default constant; int ID width derived as clog2(N_INT).
  - Typedef for a stack entry {pc, id}.
  - Function for lowest-set-bit priority encoding.
- Sub-module int_pend_arb: edge detection, pending flags, mask gating and priority encode. Outputs valid and k; input clear_k.

Test Plan:
- Reset low mid-run -> pc_out = 0, int_active = 0 and int_pending = 0 immediately; 3 steps with no jump -> pc_out = 3.
- pc_out = 10, jump = 1, offset = 1, jump_addr = 5, step -> 15. offset = 0, jump_addr = 100 -> 100. pc_out = 2^27-1, step -> 0.
- int_req rises on channels 5 and 2 together; next step at pc_out = 20 -> pc_out = 3, int_id = 2, int_pending = 0x20. reti -> pc_out = 21. Next step -> pc_out = 6, int_id = 5.
- int_mask[1] = 1 with channel 1 pulsed -> int_pending[1] = 1, no entry. Unmask -> entry on the next step to pc_out = 2.
- pc_out = ROM_BASE + 4 with channel 0 pending -> normal advance to ROM_BASE + 5 and int_pending[0] stays set.
- With PC_INT_NESTED_EN: in channel 3 handler, channel 1 fires -> preempts, pc_out = 2. reti -> back into the channel 3 handler, int_id = 3. Channel 6 during the channel 3 handler -> held pending.

Source files
------------

// File: rtl/pc_int_pkg.sv
// Shared constants, stack-entry type and priority encoder for the PC /
// interrupt controller.
// Build option: PC_INT_NESTED_EN (nested interrupts, see pc_int_ctrl).
package pc_int_pkg;

    localparam int unsigned PC_W_DEF  = 27;
    localparam int unsigned N_INT_DEF = 8;
    localparam int unsigned ID_W_DEF  = (N_INT_DEF > 1) ? $clog2(N_INT_DEF) : 1;

    // Widest request vector the priority encoder handles.
    localparam int unsigned N_INT_MAX = 32;
    localparam int unsigned IDX_W_MAX = $clog2(N_INT_MAX);

    // Return-stack entry: resume address plus the interrupted handler's ID.
    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [ID_W_DEF-1:0] id;
    } stack_entry_t;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [IDX_W_MAX-1:0] lowest_set(input logic [N_INT_MAX-1:0] vec);
        logic [IDX_W_MAX-1:0] idx;
        idx = '0;
        for (int i = N_INT_MAX - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W_MAX'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pc_int_ctrl_int_pend_arb.sv
// int_pend_arb: rising-edge detection on the request lines, pending flags,
// mask gating and lowest-index-first selection.
// Ports:
//   clk, reset           clock (state on negedge), async active-low reset
//   int_req, int_mask    request lines, 1 = channel masked
//   clear_en, clear_k    clear pending flag clear_k (accepted interrupt)
//   pending              latched pending flags (registered)
//   valid_c, k_c         an unmasked flag is pending / its lowest index
module int_pend_arb
    import pc_int_pkg::*;
#(
    parameter int unsigned N_INT = N_INT_DEF,
    parameter int unsigned ID_W  = (N_INT > 1) ? $clog2(N_INT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_INT-1:0] int_req,
    input  logic [N_INT-1:0] int_mask,
    input  logic             clear_en,
    input  logic [ID_W-1:0]  clear_k,
    output logic [N_INT-1:0] pending,
    output logic             valid_c,
    output logic [ID_W-1:0]  k_c
);

    logic [N_INT-1:0] req_prev;
    logic [N_INT-1:0] clear_vec;
    logic [N_INT-1:0] pending_nxt;
    logic [N_INT-1:0] cand;

    // A fresh edge on the accepted channel re-arms its flag.
    always_comb begin
        clear_vec = '0;
        if (clear_en) clear_vec[clear_k] = 1'b1;
        pending_nxt = (pending & ~clear_vec) | (int_req & ~req_prev);
    end

    assign cand    = pending & ~int_mask;
    assign valid_c = |cand;
    assign k_c     = ID_W'(lowest_set(N_INT_MAX'(cand)));

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            req_prev <= '0;
            pending  <= '0;
        end else begin
            req_prev <= int_req;
            pending  <= pending_nxt;
        end
    end

endmodule

// File: rtl/pc_int_ctrl.sv
// pc_int_ctrl: program counter with prioritised, maskable, edge-triggered
// interrupts. Steps once per rising edge of write_back (sampled on negedge
// clk): reti > interrupt entry > jump / sequential advance.
// Build option: PC_INT_NESTED_EN replaces the single backup register by a
// NEST_DEPTH-deep return stack allowing higher-priority preemption.
// Ports:
//   clk, reset            clock (state on negedge), async active-low reset
//   write_back            CPU write-back strobe, rising edge = step
//   jump, offset          jump this step, jump is PC-relative
//   jump_addr             jump target or relative offset
//   reti                  return from interrupt
//   int_req, int_mask     request lines, 1 = channel masked
//   pc_out                current PC
//   int_id                ID of the last accepted interrupt
//   int_active            handler in progress
//   int_pending           latched pending flags
module pc_int_ctrl
    import pc_int_pkg::*;
#(
    parameter  int unsigned      PC_W       = PC_W_DEF,
    parameter  int unsigned      N_INT      = N_INT_DEF,
    parameter  logic [PC_W-1:0]  RESET_PC   = '0,
    parameter  logic [PC_W-1:0]  ROM_BASE   = PC_W'(27'h4000000),
    parameter  logic [PC_W-1:0]  VEC_BASE   = PC_W'(1),
    parameter  int unsigned      NEST_DEPTH = 4,
    localparam int unsigned      ID_W       = (N_INT > 1) ? $clog2(N_INT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_back,
    input  logic             jump,
    input  logic             offset,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             reti,
    input  logic [N_INT-1:0] int_req,
    input  logic [N_INT-1:0] int_mask,
    output logic [PC_W-1:0]  pc_out,
    output logic [ID_W-1:0]  int_id,
    output logic             int_active,
    output logic [N_INT-1:0] int_pending
);

    logic            wb_prev;
    logic            step;
    logic            arb_valid;
    logic [ID_W-1:0] arb_k;
    logic            can_enter;
    logic            do_reti;
    logic            do_enter;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] pc_nxt;
    logic [ID_W-1:0] id_nxt;
    logic            active_nxt;

    int_pend_arb #(
        .N_INT (N_INT),
        .ID_W  (ID_W)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .int_req  (int_req),
        .int_mask (int_mask),
        .clear_en (do_enter),
        .clear_k  (arb_k),
        .pending  (int_pending),
        .valid_c  (arb_valid),
        .k_c      (arb_k)
    );

`ifdef PC_INT_NESTED_EN
    localparam int unsigned SP_W  = $clog2(NEST_DEPTH + 1);
    localparam int unsigned IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    stack_entry_t       stack [NEST_DEPTH];
    logic [SP_W-1:0]    sp;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;

    assign push_idx = IDX_W'(sp);
    assign pop_idx  = IDX_W'(sp - SP_W'(1));

    // Preemption only by a strictly higher-priority channel with stack room.
    assign can_enter = arb_valid && (pc_out < ROM_BASE) &&
                       (!int_active || ((arb_k < int_id) && (sp != SP_W'(NEST_DEPTH))));
`else
    logic [PC_W-1:0]    backup;

    assign can_enter = arb_valid && (pc_out < ROM_BASE) && !int_active;
`endif

    assign step     = write_back && !wb_prev;
    assign do_reti  = step && reti;
    assign do_enter = step && !reti && can_enter;

    // Next PC and register updates for this cycle.
    always_comb begin
        next_pc    = pc_out + PC_W'(1);
        pc_nxt     = pc_out;
        id_nxt     = int_id;
        active_nxt = int_active;

        if (jump) next_pc = offset ? (pc_out + jump_addr) : jump_addr;

        if (do_reti) begin
`ifdef PC_INT_NESTED_EN
            if (sp == '0) begin
                pc_nxt = '0;
            end else begin
                pc_nxt     = PC_W'(stack[pop_idx].pc);
                id_nxt     = ID_W'(stack[pop_idx].id);
                active_nxt = (sp != SP_W'(1));
            end
`else
            pc_nxt     = backup;
            active_nxt = 1'b0;
`endif
        end else if (do_enter) begin
            pc_nxt     = VEC_BASE + PC_W'(arb_k);
            id_nxt     = arb_k;
            active_nxt = 1'b1;
        end else if (step) begin
            pc_nxt = next_pc;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc_out     <= RESET_PC;
            int_id     <= '0;
            int_active <= 1'b0;
            wb_prev    <= 1'b0;
`ifdef PC_INT_NESTED_EN
            sp         <= '0;
            for (int i = 0; i < int'(NEST_DEPTH); i++) stack[i] <= '0;
`else
            backup     <= '0;
`endif
        end else begin
            wb_prev    <= write_back;
            pc_out     <= pc_nxt;
            int_id     <= id_nxt;
            int_active <= active_nxt;
`ifdef PC_INT_NESTED_EN
            if (do_enter) begin
                stack[push_idx] <= '{pc: PC_W_DEF'(next_pc), id: ID_W_DEF'(int_id)};
                sp              <= sp + SP_W'(1);
            end else if (do_reti && (sp != '0)) begin
                sp <= sp - SP_W'(1);
            end
`else
            if (do_enter) backup <= next_pc;
`endif
        end
    end

endmodule
